// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-side bundle between imem_fetch_ctrl, the instruction memory and decode.
// master = fetch controller, slave = memory/decode environment.
interface imem_fetch_ctrl_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        halt_req;
   logic        halted;
   logic        misaligned;
   logic [15:0] instr_count;

   modport master (
      output imem_addr, instr_out, pc_out, instr_valid, halted, misaligned, instr_count,
      input  imem_data, instr_ready, redirect, redirect_pc, halt_req
   );

   modport slave (
      input  imem_addr, instr_out, pc_out, instr_valid, halted, misaligned, instr_count,
      output imem_data, instr_ready, redirect, redirect_pc, halt_req
   );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches from a combinational imem
// and hands words to decode over valid/ready, with redirect, drain and halt.
module imem_fetch_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'd0,
   parameter logic [31:0] LAST_ADDR = 32'd84
) (
   input  logic                clk,
   input  logic                reset,
   imem_fetch_ctrl_if.master   bus
);

   typedef enum logic [1:0] {FETCH, DRAIN, HALT} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_out_q, pc_out_d;
   logic        valid_q, valid_d;
   logic        halt_q, halt_d;
   logic        mis_q, mis_d;
   logic [15:0] count_q, count_d;

   logic xfer;
   logic slot_free;

   assign xfer      = valid_q & bus.instr_ready;
   assign slot_free = ~valid_q | xfer;

   // NOTE: every variable gets a default before any branch, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      pc_out_d = pc_out_q;
      valid_d  = valid_q;
      halt_d   = halt_q | bus.halt_req;
      mis_d    = mis_q;
      count_d  = count_q;

      if (xfer) begin
         valid_d = 1'b0;
         if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
      end

      if (bus.redirect) begin
         pc_d    = bus.redirect_pc;
         valid_d = 1'b0;
         if (bus.redirect_pc[1:0] != 2'b00) begin
            mis_d   = 1'b1;
            state_d = HALT;
         end else if (halt_d || mis_q) begin
            // A misaligned fault stays fatal until reset, like a latched halt.
            state_d = HALT;
         end else begin
            state_d = FETCH;
         end
      end else begin
         unique case (state_q)
            FETCH: begin
               if (halt_d || (pc_q > LAST_ADDR)) begin
                  state_d = DRAIN;
               end else if (slot_free) begin
                  instr_d  = bus.imem_data;
                  pc_out_d = pc_q;
                  valid_d  = 1'b1;
                  pc_d     = pc_q + 32'd4;
               end
            end
            DRAIN: begin
               if (!valid_d) state_d = HALT;
            end
            HALT: begin
               valid_d = 1'b0;
            end
            default: state_d = HALT;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= FETCH;
         pc_q     <= RESET_PC;
         instr_q  <= 32'd0;
         pc_out_q <= 32'd0;
         valid_q  <= 1'b0;
         halt_q   <= 1'b0;
         mis_q    <= 1'b0;
         count_q  <= 16'd0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         pc_out_q <= pc_out_d;
         valid_q  <= valid_d;
         halt_q   <= halt_d;
         mis_q    <= mis_d;
         count_q  <= count_d;
      end
   end

   assign bus.imem_addr   = pc_q;
   assign bus.instr_out   = instr_q;
   assign bus.pc_out      = pc_out_q;
   assign bus.instr_valid = valid_q;
   assign bus.halted      = (state_q == HALT);
   assign bus.misaligned  = mis_q;
   assign bus.instr_count = count_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: directed scenarios push expected
// transfers; a negedge monitor pops and compares every accepted handshake.
module tb_imem_fetch_ctrl;

   logic clk = 1'b0;
   logic reset;

   imem_fetch_ctrl_if bus_if ();

   imem_fetch_ctrl #(.RESET_PC(32'd0), .LAST_ADDR(32'd84)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if.master)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mon_exp;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   assign bus_if.imem_data = mem_word(bus_if.imem_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset === 1'b0 && bus_if.instr_valid && bus_if.instr_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected actual pc_out=%h required=no transfer", bus_if.pc_out);
         end else begin
            mon_exp = exp_q.pop_front();
            check("sb_pc", bus_if.pc_out, mon_exp);
            check("sb_instr", bus_if.instr_out, mem_word(mon_exp));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sb_done();
      check("sb_leftover", exp_q.size(), 32'd0);
      exp_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, bus_if.instr_valid, 32'd0);
      check({tag, "_pc_out"}, bus_if.pc_out, 32'd0);
      check({tag, "_instr"}, bus_if.instr_out, 32'd0);
      check({tag, "_addr"}, bus_if.imem_addr, 32'd0);
      check({tag, "_halted"}, bus_if.halted, 32'd0);
      check({tag, "_mis"}, bus_if.misaligned, 32'd0);
      check({tag, "_count"}, bus_if.instr_count, 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus_if.instr_ready = 1'b0;
      bus_if.redirect    = 1'b0;
      bus_if.redirect_pc = 32'd0;
      bus_if.halt_req    = 1'b0;
      #3;
      check_reset_outputs("rst");
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;

      // Free run to the end of the program
      do_reset();
      bus_if.instr_ready = 1'b1;
      for (int i = 0; i < 22; i++) exp_q.push_back(32'(4 * i));
      step(22);
      check("run_last_pc", bus_if.pc_out, 32'd84);
      step(1);
      check("run_valid_off", bus_if.instr_valid, 32'd0);
      check("run_not_halted_yet", bus_if.halted, 32'd0);
      step(1);
      check("run_halted", bus_if.halted, 32'd1);
      check("run_count", bus_if.instr_count, 32'd22);
      sb_done();

      // Back-pressure while pc_out = 8
      do_reset();
      bus_if.instr_ready = 1'b1;
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd4);
      exp_q.push_back(32'd8);
      step(3);
      bus_if.instr_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         check("bp_pc_out", bus_if.pc_out, 32'd8);
         check("bp_instr", bus_if.instr_out, mem_word(32'd8));
         check("bp_addr", bus_if.imem_addr, 32'd12);
         check("bp_valid", bus_if.instr_valid, 32'd1);
      end
      bus_if.instr_ready = 1'b1;
      step(1);
      check("bp_resume_pc", bus_if.pc_out, 32'd12);
      bus_if.instr_ready = 1'b0;
      check("bp_count", bus_if.instr_count, 32'd3);
      sb_done();

      // Redirect to 0x38 while pc_out = 0x10
      do_reset();
      bus_if.instr_ready = 1'b1;
      exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h38};
      step(5);
      bus_if.redirect    = 1'b1;
      bus_if.redirect_pc = 32'h38;
      step(1);
      bus_if.redirect = 1'b0;
      check("rd_bubble", bus_if.instr_valid, 32'd0);
      check("rd_addr", bus_if.imem_addr, 32'h38);
      check("rd_count_old", bus_if.instr_count, 32'd5);
      step(1);
      check("rd_target", bus_if.pc_out, 32'h38);
      step(1);
      check("rd_next", bus_if.pc_out, 32'h3C);
      bus_if.instr_ready = 1'b0;
      check("rd_count", bus_if.instr_count, 32'd6);
      sb_done();

      // Misaligned redirect is fatal until reset
      do_reset();
      bus_if.instr_ready = 1'b1;
      step(1);
      bus_if.instr_ready = 1'b0;
      bus_if.redirect    = 1'b1;
      bus_if.redirect_pc = 32'h3A;
      step(1);
      bus_if.redirect = 1'b0;
      check("mis_flag", bus_if.misaligned, 32'd1);
      check("mis_halted", bus_if.halted, 32'd1);
      check("mis_valid", bus_if.instr_valid, 32'd0);
      check("mis_addr", bus_if.imem_addr, 32'h3A);
      bus_if.instr_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1);
         check("mis_no_fetch", bus_if.instr_valid, 32'd0);
      end
      bus_if.redirect    = 1'b1;
      bus_if.redirect_pc = 32'h0;
      step(1);
      bus_if.redirect = 1'b0;
      check("mis_redir_addr", bus_if.imem_addr, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step(1);
         check("mis_stay_valid", bus_if.instr_valid, 32'd0);
         check("mis_stay_halted", bus_if.halted, 32'd1);
      end
      check("mis_count", bus_if.instr_count, 32'd0);
      sb_done();

      // halt_req pulse during a stall
      do_reset();
      bus_if.instr_ready = 1'b1;
      exp_q = '{32'h0, 32'h4, 32'h8};
      step(3);
      bus_if.instr_ready = 1'b0;
      bus_if.halt_req    = 1'b1;
      step(1);
      bus_if.halt_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) step(1);
         check("hr_hold_pc", bus_if.pc_out, 32'd8);
         check("hr_hold_valid", bus_if.instr_valid, 32'd1);
         check("hr_not_halted", bus_if.halted, 32'd0);
      end
      bus_if.instr_ready = 1'b1;
      step(1);
      check("hr_halted", bus_if.halted, 32'd1);
      check("hr_valid", bus_if.instr_valid, 32'd0);
      check("hr_count", bus_if.instr_count, 32'd3);
      step(2);
      check("hr_stay_halted", bus_if.halted, 32'd1);
      check("hr_stay_valid", bus_if.instr_valid, 32'd0);
      sb_done();

      // Asynchronous reset in the middle of a stall
      do_reset();
      bus_if.instr_ready = 1'b1;
      exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
      step(6);
      bus_if.instr_ready = 1'b0;
      step(2);
      check("ar_stall_pc", bus_if.pc_out, 32'd20);
      #3;
      reset = 1'b1;
      #1;
      check_reset_outputs("ar");
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus_if.instr_ready = 1'b1;
      step(1);
      bus_if.instr_ready = 1'b0;
      check("ar_first_pc", bus_if.pc_out, 32'd0);
      check("ar_first_valid", bus_if.instr_valid, 32'd1);
      check("ar_first_instr", bus_if.instr_out, mem_word(32'd0));
      sb_done();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
